// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage: FSM states,
// load funct3 codes and memory-control field positions.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RDW  = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int MCR_STORE = 5;
  localparam int MCR_LOAD  = 4;

endpackage

// File: rtl/load_data_align.sv
// Selects the addressed byte/half/word from a load response word and
// sign- or zero-extends it according to funct3.
module load_data_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] read_data,
  input  logic [1:0]  offset,
  input  logic [2:0]  f3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = read_data[7:0];
    case (offset)
      2'd1:    byte_sel = read_data[15:8];
      2'd2:    byte_sel = read_data[23:16];
      2'd3:    byte_sel = read_data[31:24];
      default: byte_sel = read_data[7:0];
    endcase
    half_sel = offset[1] ? read_data[31:16] : read_data[15:0];

    // Unsupported widths fall back to the full word.
    case (f3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'h000000, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'h0000, half_sel};
      default: data = read_data;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Memory-access stage: data-memory handshake, load alignment and a registered
// writeback bundle. Optional performance counters under MEM_PERF_CNT_EN.
//
// state | meaning
// IDLE  | waiting for an instruction; non-memory ops retire from here
// REQ   | request held on the memory bus until Mem_Req_Ready
// RDW   | load accepted, waiting for Read_data_Valid
module stage_mem
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        Done_I,
  input  logic [31:0] PC_I,
  input  logic [5:0]  MCR,
  input  logic [31:0] WDR,
  input  logic [31:0] ASR,
  input  logic [4:0]  RAR,
  input  logic [2:0]  F3R,
  output logic        Feedback_Mem_Acc,
  output logic [31:0] Address,
  output logic        MemWrite,
  output logic [31:0] Write_data,
  output logic [3:0]  Write_strb,
  output logic        MemRead,
  input  logic        Mem_Req_Ready,
  input  logic [31:0] Read_data,
  input  logic        Read_data_Valid,
  output logic        Read_data_Ready,
  output logic        Done_O,
  output logic [31:0] PC_O,
  output logic        RF_wen,
  output logic [4:0]  RF_waddr,
  output logic [31:0] RF_wdata,
  output logic [31:0] Load_cnt,
  output logic [31:0] Store_cnt,
  output logic [31:0] Stall_cnt
);

  state_t      state;
  logic        is_store, is_load, mem_op;
  logic        store_done, load_done, complete;
  logic [31:0] load_data;

  assign is_store   = MCR[MCR_STORE];
  assign is_load    = MCR[MCR_LOAD];
  assign mem_op     = is_store | is_load;
  assign store_done = (state == REQ) & is_store & Mem_Req_Ready;
  assign load_done  = (state == RDW) & Read_data_Valid;
  assign complete   = store_done | load_done;

  assign Feedback_Mem_Acc = Done_I & mem_op & ~complete;

  // Bus strobes decode straight from state so reset drops them immediately.
  assign MemRead         = (state == REQ) & is_load;
  assign MemWrite        = (state == REQ) & is_store;
  assign Read_data_Ready = (state == RDW);
  assign Address         = {ASR[31:2], 2'b00};
  assign Write_data      = WDR;
  assign Write_strb      = MCR[3:0];

  load_data_align u_align (
    .read_data (Read_data),
    .offset    (ASR[1:0]),
    .f3        (F3R),
    .data      (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      Done_O   <= 1'b0;
      PC_O     <= 32'h0;
      RF_wen   <= 1'b0;
      RF_waddr <= 5'd0;
      RF_wdata <= 32'h0;
    end else begin
      Done_O <= 1'b0;
      RF_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (Done_I) begin
            if (mem_op) begin
              state <= REQ;
            end else begin
              Done_O   <= 1'b1;
              PC_O     <= PC_I;
              RF_wen   <= (RAR != 5'd0);
              RF_waddr <= RAR;
              RF_wdata <= ASR;
            end
          end
        end
        REQ: begin
          if (Mem_Req_Ready) begin
            if (is_store) begin
              state    <= IDLE;
              Done_O   <= 1'b1;
              PC_O     <= PC_I;
              RF_waddr <= RAR;
            end else begin
              state <= RDW;
            end
          end
        end
        RDW: begin
          if (Read_data_Valid) begin
            state    <= IDLE;
            Done_O   <= 1'b1;
            PC_O     <= PC_I;
            RF_wen   <= (RAR != 5'd0);
            RF_waddr <= RAR;
            RF_wdata <= load_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Load_cnt  <= 32'h0;
      Store_cnt <= 32'h0;
      Stall_cnt <= 32'h0;
    end else begin
      if (load_done)        Load_cnt  <= Load_cnt + 32'd1;
      if (store_done)       Store_cnt <= Store_cnt + 32'd1;
      if (Feedback_Mem_Acc) Stall_cnt <= Stall_cnt + 32'd1;
    end
  end
`else
  assign Load_cnt  = 32'h0;
  assign Store_cnt = 32'h0;
  assign Stall_cnt = 32'h0;
`endif

endmodule
